log_writer_in_ctrl: RTL and testbench

Input-side control for the replicated log. It accepts a batch start address, then a sequence of per-entry headers and data-line streams from the network/parse side. It writes every line into log memory with the entry address and line offset, and advances the entry address per entry. It is the write-end counterpart of the log reader's output control, sharing its entry/line addressing.

---
 rtl/log_pkg.sv | 16 +
 rtl/log_writer_in_ctrl_if.sv | 43 ++++
 rtl/log_writer_in_ctrl.sv | 141 ++++++++++++++
 tb/tb_log_writer_in_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared log addressing package: default widths and writer FSM states.
// Used by both the writer input control and the reader output control.
package log_pkg;

  localparam int LOG_ENTRY_ADDR_W = 10;
  localparam int LINE_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    DROP = 3'd3,
    DONE = 3'd4
  } log_writer_state_e;

endpackage

// File: rtl/log_writer_in_ctrl_if.sv
// Handshake bundle for the log writer input control.
// master: network/parse source + log memory (drives requests and write ready).
// slave : the writer control block.
interface log_writer_in_ctrl_if #(
  parameter int LOG_ENTRY_ADDR_W = log_pkg::LOG_ENTRY_ADDR_W,
  parameter int LINE_CNT_W       = log_pkg::LINE_CNT_W
);
  logic                        start_req_val;
  logic [LOG_ENTRY_ADDR_W-1:0] start_req_addr;
  logic                        start_req_rdy;
  logic                        src_writer_hdr_val;
  logic [LINE_CNT_W-1:0]       src_writer_hdr_lines_m1;
  logic                        src_writer_hdr_last_entry;
  logic                        writer_src_hdr_rdy;
  logic                        src_writer_data_val;
  logic                        src_writer_data_last;
  logic                        writer_src_data_rdy;
  logic                        out_log_wr_val;
  logic                        out_log_wr_last;
  logic                        log_out_wr_rdy;
  logic [LOG_ENTRY_ADDR_W-1:0] out_entry_addr;
  logic [LINE_CNT_W-1:0]       out_line_offset;
  logic                        batch_done;
  logic                        entry_len_err;

  modport master (
    output start_req_val, start_req_addr,
    output src_writer_hdr_val, src_writer_hdr_lines_m1, src_writer_hdr_last_entry,
    output src_writer_data_val, src_writer_data_last, log_out_wr_rdy,
    input  start_req_rdy, writer_src_hdr_rdy, writer_src_data_rdy,
    input  out_log_wr_val, out_log_wr_last, out_entry_addr, out_line_offset,
    input  batch_done, entry_len_err
  );

  modport slave (
    input  start_req_val, start_req_addr,
    input  src_writer_hdr_val, src_writer_hdr_lines_m1, src_writer_hdr_last_entry,
    input  src_writer_data_val, src_writer_data_last, log_out_wr_rdy,
    output start_req_rdy, writer_src_hdr_rdy, writer_src_data_rdy,
    output out_log_wr_val, out_log_wr_last, out_entry_addr, out_line_offset,
    output batch_done, entry_len_err
  );
endinterface

// File: rtl/log_writer_in_ctrl.sv
// Log writer input control: takes a batch start address, then per-entry
// headers and data lines, and passes lines straight through to log memory
// tagged with entry address and line offset.
// Build option LOG_WRITER_LEN_CHECK_EN: enforce header line counts, drop
// excess lines and pulse entry_len_err on any length mismatch.
module log_writer_in_ctrl #(
  parameter int LOG_ENTRY_ADDR_W = log_pkg::LOG_ENTRY_ADDR_W,
  parameter int LINE_CNT_W       = log_pkg::LINE_CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  log_writer_in_ctrl_if.slave bus
);
  import log_pkg::*;

  log_writer_state_e           r_state, w_state_nxt;
  logic [LOG_ENTRY_ADDR_W-1:0] r_entry_addr, w_entry_addr_nxt;
  logic [LINE_CNT_W-1:0]       r_line_offset, w_line_offset_nxt;
  logic                        r_last_entry;
  logic                        r_batch_done;
  logic                        w_data_hs;
  logic                        w_eoe;

`ifdef LOG_WRITER_LEN_CHECK_EN
  logic [LINE_CNT_W-1:0] r_lines_m1;
  logic                  r_len_err, w_len_err_nxt;
  logic                  w_cnt_end;

  // Entry ends on the source's last flag or when the header count is reached.
  assign w_cnt_end = (r_line_offset == r_lines_m1);
  assign w_eoe     = bus.src_writer_data_last | w_cnt_end;
`else
  assign w_eoe = bus.src_writer_data_last;
`endif

  assign w_data_hs = bus.src_writer_data_val & bus.log_out_wr_rdy;

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    w_state_nxt             = r_state;
    w_entry_addr_nxt        = r_entry_addr;
    w_line_offset_nxt       = r_line_offset;
    bus.start_req_rdy       = 1'b0;
    bus.writer_src_hdr_rdy  = 1'b0;
    bus.writer_src_data_rdy = 1'b0;
    bus.out_log_wr_val      = 1'b0;
    bus.out_log_wr_last     = 1'b0;
`ifdef LOG_WRITER_LEN_CHECK_EN
    w_len_err_nxt           = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        bus.start_req_rdy = 1'b1;
        if (bus.start_req_val) begin
          w_entry_addr_nxt = bus.start_req_addr;
          w_state_nxt      = HDR;
        end
      end
      HDR: begin
        bus.writer_src_hdr_rdy = 1'b1;
        if (bus.src_writer_hdr_val) begin
          w_line_offset_nxt = '0;
          w_state_nxt       = DATA;
        end
      end
      DATA: begin
        // Zero-latency pass-through; memory backpressure goes straight upstream.
        bus.out_log_wr_val      = bus.src_writer_data_val;
        bus.writer_src_data_rdy = bus.log_out_wr_rdy;
        bus.out_log_wr_last     = w_eoe;
        if (w_data_hs) begin
          if (w_eoe) begin
            w_entry_addr_nxt  = r_entry_addr + 1'b1;
            w_line_offset_nxt = '0;
            w_state_nxt       = r_last_entry ? DONE : HDR;
`ifdef LOG_WRITER_LEN_CHECK_EN
            if (!bus.src_writer_data_last) begin
              // Source has more lines than advertised: swallow the rest.
              w_len_err_nxt = 1'b1;
              w_state_nxt   = DROP;
            end else if (!w_cnt_end) begin
              w_len_err_nxt = 1'b1;
            end
`endif
          end else begin
            w_line_offset_nxt = r_line_offset + 1'b1;
          end
        end
      end
`ifdef LOG_WRITER_LEN_CHECK_EN
      DROP: begin
        bus.writer_src_data_rdy = 1'b1;
        if (bus.src_writer_data_val && bus.src_writer_data_last)
          w_state_nxt = r_last_entry ? DONE : HDR;
      end
`endif
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, address/offset counters, header latch and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_entry_addr  <= '0;
      r_line_offset <= '0;
      r_last_entry  <= 1'b0;
      r_batch_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry_addr  <= w_entry_addr_nxt;
      r_line_offset <= w_line_offset_nxt;
      r_batch_done  <= (w_state_nxt == DONE);
      if (r_state == HDR && bus.src_writer_hdr_val)
        r_last_entry <= bus.src_writer_hdr_last_entry;
    end
  end

`ifdef LOG_WRITER_LEN_CHECK_EN
  // Line count latch and registered length-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lines_m1 <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= w_len_err_nxt;
      if (r_state == HDR && bus.src_writer_hdr_val)
        r_lines_m1 <= bus.src_writer_hdr_lines_m1;
    end
  end
  assign bus.entry_len_err = r_len_err;
`else
  assign bus.entry_len_err = 1'b0;
`endif

  assign bus.out_entry_addr  = r_entry_addr;
  assign bus.out_line_offset = r_line_offset;
  assign bus.batch_done      = r_batch_done;

endmodule

// File: tb/tb_log_writer_in_ctrl.sv
// Testbench for log_writer_in_ctrl: directed batch table, randomized batches
// against a write-list model, and a mid-batch reset sequence.
module tb_log_writer_in_ctrl;
  localparam int AW = 10;
  localparam int LW = 8;
`ifdef LOG_WRITER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] o;
    logic          l;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            n;
    int            lm1[4];
    int            nb[4];
    int            mode;
    int            exp_wr;
    int            exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  log_writer_in_ctrl_if #(.LOG_ENTRY_ADDR_W(AW), .LINE_CNT_W(LW)) bus();
  log_writer_in_ctrl #(.LOG_ENTRY_ADDR_W(AW), .LINE_CNT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  n_done, n_err;
  int  rdy_mode = 0;
  int  cur_l[4], cur_n[4];
  wr_t got[$];
  wr_t mdl[$];
  int  mdl_err;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Memory ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    bus.log_out_wr_rdy = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.log_out_wr_rdy = 1'b1;
        1: bus.log_out_wr_rdy = ~bus.log_out_wr_rdy;
        default: bus.log_out_wr_rdy = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: record every accepted memory write and count output pulses.
  initial begin
    forever begin
      wr_t w;
      @(negedge clk);
      #2;
      if (rst_n && bus.out_log_wr_val && bus.log_out_wr_rdy) begin
        w.a = bus.out_entry_addr;
        w.o = bus.out_line_offset;
        w.l = bus.out_log_wr_last;
        got.push_back(w);
      end
      if (bus.batch_done) n_done++;
      if (bus.entry_len_err) n_err++;
    end
  end

  // Reference: the list of writes a batch should produce.
  task automatic build_model(input logic [AW-1:0] addr, input int n);
    mdl.delete();
    mdl_err = 0;
    for (int e = 0; e < n; e++) begin
      int  w;
      wr_t x;
      w = (LEN_CHK && cur_n[e] > cur_l[e] + 1) ? cur_l[e] + 1 : cur_n[e];
      if (LEN_CHK && cur_n[e] != cur_l[e] + 1) mdl_err++;
      for (int o = 0; o < w; o++) begin
        x.a = addr + AW'(e);
        x.o = LW'(o);
        x.l = (o == w - 1);
        mdl.push_back(x);
      end
    end
  endtask

  // Called at a negedge with a valid raised; returns at the posedge of handshake.
  task automatic wait_hs(input int which, output int cyc, output bit ok);
    logic r;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      #1;
      case (which)
        0: r = bus.start_req_rdy;
        1: r = bus.writer_src_hdr_rdy;
        default: r = bus.writer_src_data_rdy;
      endcase
      @(posedge clk);
      if (r) ok = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout_%0d actual=timeout required=handshake", which);
    end
  endtask

  task automatic run_batch(input logic [AW-1:0] addr, input int n, input bit lat);
    int cyc;
    bit ok;
    got.delete();
    n_done = 0;
    n_err = 0;
    @(negedge clk);
    bus.start_req_val = 1'b1;
    bus.start_req_addr = addr;
    wait_hs(0, cyc, ok);
    if (!ok) return;
    @(negedge clk);
    bus.start_req_val = 1'b0;
    for (int e = 0; e < n; e++) begin
      bus.src_writer_hdr_val = 1'b1;
      bus.src_writer_hdr_lines_m1 = LW'(cur_l[e]);
      bus.src_writer_hdr_last_entry = (e == n - 1);
      wait_hs(1, cyc, ok);
      if (!ok) return;
      if (e == 0 && lat) chk("start_to_hdr_lat", cyc, 0);
      @(negedge clk);
      bus.src_writer_hdr_val = 1'b0;
      for (int b = 0; b < cur_n[e]; b++) begin
        if (!lat && $urandom_range(2) == 0) begin
          bus.src_writer_data_val = 1'b0;
          @(negedge clk);
        end
        bus.src_writer_data_val = 1'b1;
        bus.src_writer_data_last = (b == cur_n[e] - 1);
        if (b == 0) begin
          #1;
          chk("hdr_rdy_in_data", bus.writer_src_hdr_rdy, 0);
        end
        wait_hs(2, cyc, ok);
        if (!ok) return;
        if (b == 0 && lat) chk("hdr_to_data_lat", cyc, 0);
        @(negedge clk);
        bus.src_writer_data_val = 1'b0;
        bus.src_writer_data_last = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input int exp_wr, input int exp_err, input string tag);
    chk({tag, "_wr_count"}, got.size(), exp_wr);
    for (int i = 0; i < got.size() && i < mdl.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got[i], mdl[i]);
    chk({tag, "_len_err"}, n_err, exp_err);
    chk({tag, "_done"}, n_done, 1);
  endtask

  initial begin
    int cyc;
    bit ok;
    bus.start_req_val = 1'b0;
    bus.start_req_addr = '0;
    bus.src_writer_hdr_val = 1'b0;
    bus.src_writer_hdr_lines_m1 = '0;
    bus.src_writer_hdr_last_entry = 1'b0;
    bus.src_writer_data_val = 1'b0;
    bus.src_writer_data_last = 1'b0;

    // addr, entries, lines_m1, beats, rdy mode, expected writes, expected errors
    tbl[0] = '{addr: 10'd5,    n: 2, lm1: '{2, 0, 0, 0}, nb: '{3, 1, 0, 0}, mode: 0, exp_wr: 4, exp_err: 0};
    tbl[1] = '{addr: 10'd1023, n: 3, lm1: '{0, 0, 0, 0}, nb: '{1, 1, 1, 0}, mode: 0, exp_wr: 3, exp_err: 0};
    tbl[2] = '{addr: 10'd10,   n: 1, lm1: '{3, 0, 0, 0}, nb: '{4, 0, 0, 0}, mode: 1, exp_wr: 4, exp_err: 0};
    tbl[3] = '{addr: 10'd20,   n: 2, lm1: '{3, 0, 0, 0}, nb: '{2, 1, 0, 0}, mode: 0, exp_wr: 3,
               exp_err: LEN_CHK ? 1 : 0};
    tbl[4] = '{addr: 10'd30,   n: 2, lm1: '{1, 0, 0, 0}, nb: '{4, 1, 0, 0}, mode: 0,
               exp_wr: LEN_CHK ? 3 : 5, exp_err: LEN_CHK ? 1 : 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs",
        {bus.start_req_rdy, bus.writer_src_hdr_rdy, bus.writer_src_data_rdy,
         bus.out_log_wr_val, bus.out_log_wr_last, bus.out_entry_addr,
         bus.out_line_offset, bus.batch_done, bus.entry_len_err},
        {1'b1, 4'b0, {AW{1'b0}}, {LW{1'b0}}, 2'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int t = 0; t < 5; t++) begin
      rdy_mode = tbl[t].mode;
      for (int e = 0; e < 4; e++) begin
        cur_l[e] = tbl[t].lm1[e];
        cur_n[e] = tbl[t].nb[e];
      end
      build_model(tbl[t].addr, tbl[t].n);
      run_batch(tbl[t].addr, tbl[t].n, tbl[t].mode == 0);
      compare(tbl[t].exp_wr, tbl[t].exp_err, $sformatf("tbl%0d", t));
    end

    // Randomized batches against the model
    rdy_mode = 2;
    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] a;
      int n;
      a = AW'($urandom);
      n = $urandom_range(4, 1);
      for (int e = 0; e < 4; e++) begin
        cur_l[e] = $urandom_range(4);
        cur_n[e] = ($urandom_range(3) == 0) ? $urandom_range(6, 1) : cur_l[e] + 1;
      end
      build_model(a, n);
      run_batch(a, n, 1'b0);
      compare(mdl.size(), mdl_err, $sformatf("rnd%0d", r));
    end

    // Reset while the third line of an entry is on the bus
    rdy_mode = 0;
    @(negedge clk);
    bus.start_req_val = 1'b1;
    bus.start_req_addr = 10'd40;
    wait_hs(0, cyc, ok);
    @(negedge clk);
    bus.start_req_val = 1'b0;
    bus.src_writer_hdr_val = 1'b1;
    bus.src_writer_hdr_lines_m1 = 8'd5;
    bus.src_writer_hdr_last_entry = 1'b1;
    wait_hs(1, cyc, ok);
    @(negedge clk);
    bus.src_writer_hdr_val = 1'b0;
    bus.src_writer_data_val = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_hs(2, cyc, ok);
      @(negedge clk);
    end
    #1;
    chk("pre_rst_offset", bus.out_line_offset, 2);
    chk("pre_rst_addr", bus.out_entry_addr, 40);
    n_done = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs",
        {bus.start_req_rdy, bus.writer_src_hdr_rdy, bus.writer_src_data_rdy,
         bus.out_log_wr_val, bus.out_log_wr_last, bus.out_entry_addr,
         bus.out_line_offset, bus.batch_done, bus.entry_len_err},
        {1'b1, 4'b0, {AW{1'b0}}, {LW{1'b0}}, 2'b0});
    bus.src_writer_data_val = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", n_done, 0);
    #1;
    chk("idle_after_rst", bus.start_req_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
